// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared Harris score/coordinate types and pipeline constants
package harris_pkg;

    localparam int HARRIS_SCORE_BITS = 16;
    localparam int HARRIS_COORD_BITS = 16;
    localparam int NMS_LATENCY       = 2;

    typedef logic signed [HARRIS_SCORE_BITS-1:0] score_t;
    typedef logic        [HARRIS_COORD_BITS-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        score_t score;
        logic   is_corner;
    } corner_t;

endpackage

// File: rtl/score_window3x3.sv
// rtl/score_window3x3.sv - row buffers, 3x3 raster window and centre coordinates
module score_window3x3
    import harris_pkg::*;
#(
    parameter int SCORE_BITS     = HARRIS_SCORE_BITS,
    parameter int MAX_ROW_LENGTH = 2048,
    parameter int COORD_BITS     = HARRIS_COORD_BITS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [COORD_BITS-1:0]                row_length,
    input  logic                                 in_valid,
    input  logic signed [SCORE_BITS-1:0]         in_score,
    output logic [2:0][2:0][SCORE_BITS-1:0]      window,
    output logic [COORD_BITS-1:0]                centre_x,
    output logic [COORD_BITS-1:0]                centre_y,
    output logic                                 window_valid
);

    localparam int AW = $clog2(MAX_ROW_LENGTH);

    logic [SCORE_BITS-1:0] row1_mem [MAX_ROW_LENGTH];
    logic [SCORE_BITS-1:0] row2_mem [MAX_ROW_LENGTH];
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic [AW-1:0]         addr;
    logic [SCORE_BITS-1:0] rd_row1;
    logic [SCORE_BITS-1:0] rd_row2;

    assign addr    = x[AW-1:0];
    assign rd_row1 = row1_mem[addr];
    assign rd_row2 = row2_mem[addr];

    // Row RAM is never reset; stale contents are masked by the y>=2 gating.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            row1_mem[addr] <= in_score;
            row2_mem[addr] <= rd_row1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x            <= '0;
            y            <= '0;
            window       <= '0;
            centre_x     <= '0;
            centre_y     <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= in_valid && (x >= COORD_BITS'(2)) && (y >= COORD_BITS'(2));
            if (in_valid) begin
                if (x == row_length - COORD_BITS'(1)) begin
                    x <= '0;
                    if (y != '1)
                        y <= y + COORD_BITS'(1);
                end else begin
                    x <= x + COORD_BITS'(1);
                end
                centre_x <= x - COORD_BITS'(1);
                centre_y <= y - COORD_BITS'(1);
                // Row 0 is the oldest image row, column 2 the newest column.
                for (int r = 0; r < 3; r++) begin
                    window[r][0] <= window[r][1];
                    window[r][1] <= window[r][2];
                end
                window[0][2] <= rd_row2;
                window[1][2] <= rd_row1;
                window[2][2] <= in_score;
            end
        end
    end

endmodule

// File: rtl/harris_nms.sv
// rtl/harris_nms.sv - 3x3 non-maximum suppression of Harris scores; HARRIS_NMS_COUNT_EN adds a corner counter
module harris_nms
    import harris_pkg::*;
#(
    parameter int SCORE_BITS     = HARRIS_SCORE_BITS,
    parameter int MAX_ROW_LENGTH = 2048,
    parameter int COORD_BITS     = HARRIS_COORD_BITS,
    parameter int COUNT_BITS     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COORD_BITS-1:0]        r_row_length,
    input  logic signed [SCORE_BITS-1:0] r_threshold,
    input  logic                         in_valid,
    input  logic signed [SCORE_BITS-1:0] in_score,
    output logic                         out_valid,
    output logic                         out_is_corner,
    output logic [COORD_BITS-1:0]        out_x,
    output logic [COORD_BITS-1:0]        out_y,
    output logic signed [SCORE_BITS-1:0] out_score
`ifdef HARRIS_NMS_COUNT_EN
    ,
    output logic [COUNT_BITS-1:0]        out_corner_count
`endif
);

    logic [2:0][2:0][SCORE_BITS-1:0] window;
    logic [COORD_BITS-1:0]           centre_x;
    logic [COORD_BITS-1:0]           centre_y;
    logic                            window_valid;
    logic signed [SCORE_BITS-1:0]    centre;
    logic                            peak;

    logic                            s1_valid;
    logic                            s1_corner;
    logic [COORD_BITS-1:0]           s1_x;
    logic [COORD_BITS-1:0]           s1_y;
    logic signed [SCORE_BITS-1:0]    s1_score;

    score_window3x3 #(
        .SCORE_BITS    (SCORE_BITS),
        .MAX_ROW_LENGTH(MAX_ROW_LENGTH),
        .COORD_BITS    (COORD_BITS)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .row_length  (r_row_length),
        .in_valid    (in_valid),
        .in_score    (in_score),
        .window      (window),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .window_valid(window_valid)
    );

    // Ties with earlier raster neighbours are allowed, ties with later ones are not,
    // so a plateau reports only its last pixel in raster order.
    always_comb begin
        centre = $signed(window[1][1]);
        peak   = centre > r_threshold;
        for (int c = 0; c < 3; c++) begin
            if (centre <  $signed(window[0][c])) peak = 1'b0;
            if (centre <= $signed(window[2][c])) peak = 1'b0;
        end
        if (centre <  $signed(window[1][0])) peak = 1'b0;
        if (centre <= $signed(window[1][2])) peak = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_corner     <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            s1_score      <= '0;
            out_valid     <= 1'b0;
            out_is_corner <= 1'b0;
            out_x         <= '0;
            out_y         <= '0;
            out_score     <= '0;
        end else begin
            s1_valid      <= window_valid;
            out_valid     <= s1_valid;
            out_is_corner <= s1_valid && s1_corner;
            if (window_valid) begin
                s1_corner <= peak;
                s1_x      <= centre_x;
                s1_y      <= centre_y;
                s1_score  <= centre;
            end
            if (s1_valid) begin
                out_x     <= s1_x;
                out_y     <= s1_y;
                out_score <= s1_score;
            end
        end
    end

`ifdef HARRIS_NMS_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_corner_count <= '0;
        else if (out_valid && out_is_corner && (out_corner_count != '1))
            out_corner_count <= out_corner_count + COUNT_BITS'(1);
    end
`endif

endmodule
